// File: rtl/axi4_wr_arbiter_if.sv
// rtl/axi4_wr_arbiter_if.sv - bus bundle for the round-robin AXI4 write-path arbiter
// slave  : the arbiter's view (takes per-slot requests, drives the downstream port)
// master : the surrounding system's view (per-slot masters plus downstream memory)
interface axi4_wr_arbiter_if #(
   parameter int slot_num_p   = 4,
   parameter int id_width_p   = 6,
   parameter int addr_width_p = 64,
   parameter int data_width_p = 512
);
   localparam int aw_w_c = id_width_p + addr_width_p + 8;
   localparam int w_w_c  = data_width_p + data_width_p / 8 + 1;
   localparam int b_w_c  = id_width_p + 2;

   // upstream, one lane per slot; payloads packed slot 0 in the low bits
   logic [slot_num_p-1:0]        s_awvalid_i;
   logic [slot_num_p-1:0]        s_awready_o;
   logic [slot_num_p*aw_w_c-1:0] s_aw_i;
   logic [slot_num_p-1:0]        s_wvalid_i;
   logic [slot_num_p-1:0]        s_wready_o;
   logic [slot_num_p*w_w_c-1:0]  s_w_i;
   logic [slot_num_p-1:0]        s_bvalid_o;
   logic [slot_num_p-1:0]        s_bready_i;
   logic [b_w_c-1:0]             s_b_o;

   // downstream, single port toward memory
   logic                         m_awvalid_o;
   logic                         m_awready_i;
   logic [aw_w_c-1:0]            m_aw_o;
   logic                         m_wvalid_o;
   logic                         m_wready_i;
   logic [w_w_c-1:0]             m_w_o;
   logic                         m_bvalid_i;
   logic                         m_bready_o;
   logic [b_w_c-1:0]             m_b_i;

   modport slave (
      input  s_awvalid_i, s_aw_i, s_wvalid_i, s_w_i, s_bready_i,
      input  m_awready_i, m_wready_i, m_bvalid_i, m_b_i,
      output s_awready_o, s_wready_o, s_bvalid_o, s_b_o,
      output m_awvalid_o, m_aw_o, m_wvalid_o, m_w_o, m_bready_o
   );

   modport master (
      output s_awvalid_i, s_aw_i, s_wvalid_i, s_w_i, s_bready_i,
      output m_awready_i, m_wready_i, m_bvalid_i, m_b_i,
      input  s_awready_o, s_wready_o, s_bvalid_o, s_b_o,
      input  m_awvalid_o, m_aw_o, m_wvalid_o, m_w_o, m_bready_o
   );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// rtl/axi4_wr_arbiter.sv - round-robin arbiter sharing one AXI4 write path; optional stall flag under AXI4_WR_ARB_TIMEOUT_EN
module axi4_wr_arbiter #(
   parameter int slot_num_p   = 4,
   parameter int id_width_p   = 6,
   parameter int addr_width_p = 64,
   parameter int data_width_p = 512,
   parameter int timeout_p    = 1024
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   axi4_wr_arbiter_if.slave      bus,
   output logic [slot_num_p-1:0] grant_o,
   output logic                  busy_o,
   output logic                  timeout_o
);
   localparam int aw_w_c  = id_width_p + addr_width_p + 8;
   localparam int w_w_c   = data_width_p + data_width_p / 8 + 1;
   localparam int idx_w_c = $clog2(slot_num_p);
   localparam int cnd_w_c = idx_w_c + 1;

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_addr = 2'd1;
   localparam logic [1:0] st_data = 2'd2;
   localparam logic [1:0] st_resp = 2'd3;

   // Reject configurations the search and pointer logic are not sized for.
   if (slot_num_p < 2 || slot_num_p > 16 || timeout_p < 1) begin : g_bad_params
      $error("axi4_wr_arbiter: slot_num_p must be 2..16 and timeout_p at least 1");
   end

   logic [1:0]            state_q, state_d;
   logic [slot_num_p-1:0] grant_q, grant_d;
   logic [idx_w_c-1:0]    gidx_q, gidx_d;
   logic [idx_w_c-1:0]    ptr_q, ptr_d;

   logic                  any_req;
   logic [idx_w_c-1:0]    win_idx;
   logic [aw_w_c-1:0]     sel_aw;
   logic [w_w_c-1:0]      sel_w;
   logic                  aw_hs;
   logic                  w_beat;
   logic                  w_last_hs;
   logic                  b_hs;

   // Payload of the granted slot; the binary index avoids a one-hot mux tree.
   assign sel_aw = bus.s_aw_i[int'(gidx_q) * aw_w_c +: aw_w_c];
   assign sel_w  = bus.s_w_i[int'(gidx_q) * w_w_c +: w_w_c];

   assign aw_hs     = bus.m_awvalid_o & bus.m_awready_i;
   assign w_beat    = bus.m_wvalid_o & bus.m_wready_i;
   assign w_last_hs = w_beat & sel_w[0];
   assign b_hs      = bus.m_bvalid_i & bus.m_bready_o;

   assign grant_o = grant_q;
   assign busy_o  = (state_q != st_idle);

   // Round-robin search: first requester at or after the pointer, wrapping past the top slot.
   always_comb begin : arb_search
      logic [cnd_w_c-1:0] cand;
      any_req = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 0; i < slot_num_p; i++) begin
         cand = {1'b0, ptr_q} + cnd_w_c'(i);
         if (cand >= cnd_w_c'(slot_num_p)) begin
            cand = cand - cnd_w_c'(slot_num_p);
         end
         if (!any_req && bus.s_awvalid_i[cand]) begin
            any_req = 1'b1;
            win_idx = cand[idx_w_c-1:0];
         end
      end
   end

   // Transaction sequencing: one write (address, burst, response) at a time.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      case (state_q)
         st_idle: begin
            if (any_req) begin
               state_d          = st_addr;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               gidx_d           = win_idx;
               if (win_idx == idx_w_c'(slot_num_p - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = win_idx + 1'b1;
               end
            end
         end
         st_addr: begin
            if (aw_hs) begin
               state_d = st_data;
            end
         end
         st_data: begin
            if (w_last_hs) begin
               state_d = st_resp;
            end
         end
         st_resp: begin
            if (b_hs) begin
               state_d = st_idle;
               grant_d = '0;
            end
         end
         default: begin
            state_d = st_idle;
            grant_d = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= st_idle;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
      end
   end

   // Channel steering: only the active channel of the granted slot sees valid/ready.
   always_comb begin
      bus.m_awvalid_o = 1'b0;
      bus.m_wvalid_o  = 1'b0;
      bus.m_bready_o  = 1'b0;
      bus.s_awready_o = '0;
      bus.s_wready_o  = '0;
      bus.s_bvalid_o  = '0;
      bus.m_aw_o      = sel_aw;
      bus.m_w_o       = sel_w;
      bus.s_b_o       = bus.m_b_i;
      case (state_q)
         st_addr: begin
            bus.m_awvalid_o         = bus.s_awvalid_i[gidx_q];
            bus.s_awready_o[gidx_q] = bus.m_awready_i;
         end
         st_data: begin
            bus.m_wvalid_o         = bus.s_wvalid_i[gidx_q];
            bus.s_wready_o[gidx_q] = bus.m_wready_i;
         end
         st_resp: begin
            bus.s_bvalid_o[gidx_q] = bus.m_bvalid_i;
            bus.m_bready_o         = bus.s_bready_i[gidx_q];
         end
         default: begin
            bus.m_awvalid_o = 1'b0;
         end
      endcase
   end

`ifdef AXI4_WR_ARB_TIMEOUT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        timeout_q, timeout_d;

   // Stall counter: restarts on any downstream handshake or state change, saturates at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      timeout_d   = timeout_q;
      if (state_q == st_idle || state_d != state_q || aw_hs || w_beat || b_hs) begin
         stall_cnt_d = '0;
      end else if (stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (stall_cnt_d == 32'(timeout_p)) begin
         timeout_d = 1'b1;
      end
   end

   // Sticky stall flag; only reset clears it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// tb/tb_axi4_wr_arbiter.sv - directed self-checking bench for axi4_wr_arbiter
module tb_axi4_wr_arbiter;
   localparam int slot_n = 4;
   localparam int id_w   = 6;
   localparam int addr_w = 64;
   localparam int data_w = 512;
   localparam int to_p   = 16;
   localparam int aw_w   = id_w + addr_w + 8;
   localparam int w_w    = data_w + data_w / 8 + 1;

`ifdef AXI4_WR_ARB_TIMEOUT_EN
   localparam logic to_en = 1'b1;
`else
   localparam logic to_en = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [slot_n-1:0] grant;
   logic              busy;
   logic              timeout;
   int                n_chk = 0;
   int                n_fail = 0;
   int                beats;
   logic [slot_n-1:0] exp_g;
   logic [w_w-1:0]    exp_w;

   axi4_wr_arbiter_if #(
      .slot_num_p(slot_n), .id_width_p(id_w), .addr_width_p(addr_w), .data_width_p(data_w)
   ) bus ();

   axi4_wr_arbiter #(
      .slot_num_p(slot_n), .id_width_p(id_w), .addr_width_p(addr_w),
      .data_width_p(data_w), .timeout_p(to_p)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n), .bus(bus),
      .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [aw_w-1:0] mk_aw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
      return {id, addr, len};
   endfunction

   function automatic logic [w_w-1:0] mk_w(input logic [31:0] tag, input logic last);
      logic [data_w-1:0] d;
      d = '0;
      d[31:0] = tag;
      return {d, {(data_w/8){1'b1}}, last};
   endfunction

   task automatic set_aw(input int s, input logic [aw_w-1:0] v);
      bus.s_aw_i[s*aw_w +: aw_w] = v;
   endtask

   task automatic set_w(input int s, input logic [w_w-1:0] v);
      bus.s_w_i[s*w_w +: w_w] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.s_awvalid_i = '0;
      bus.s_aw_i      = '0;
      bus.s_wvalid_i  = '0;
      bus.s_w_i       = '0;
      bus.s_bready_i  = '0;
      bus.m_awready_i = 1'b0;
      bus.m_wready_i  = 1'b0;
      bus.m_bvalid_i  = 1'b0;
      bus.m_b_i       = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      // 1: reset state
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      check("t1_m_awvalid", bus.m_awvalid_o, 1'b0);
      check("t1_m_wvalid", bus.m_wvalid_o, 1'b0);
      check("t1_m_bready", bus.m_bready_o, 1'b0);
      check("t1_s_awready", bus.s_awready_o, 4'b0000);
      check("t1_s_wready", bus.s_wready_o, 4'b0000);
      check("t1_s_bvalid", bus.s_bvalid_o, 4'b0000);
      check("t1_grant", grant, 4'b0000);
      check("t1_busy", busy, 1'b0);
      check("t1_timeout", timeout, 1'b0);
      rst_n = 1'b1;
      step();

      // 2: slot 2, 4-beat burst, bid=5
      bus.m_awready_i = 1'b1;
      bus.m_wready_i  = 1'b1;
      bus.s_awvalid_i = 4'b0100;
      set_aw(2, mk_aw(6'd5, 64'h0000_0000_0000_1000, 8'd3));
      set_w(2, mk_w(32'hA0, 1'b0));
      bus.s_wvalid_i  = 4'b0100;
      #1;
      check("t2_awvalid_not_yet", bus.m_awvalid_o, 1'b0);
      step();
      check("t2_grant", grant, 4'b0100);
      check("t2_busy", busy, 1'b1);
      check("t2_m_awvalid", bus.m_awvalid_o, 1'b1);
      check("t2_m_aw", bus.m_aw_o, mk_aw(6'd5, 64'h0000_0000_0000_1000, 8'd3));
      check("t2_s_awready", bus.s_awready_o, 4'b0100);
      check("t2_early_wready", bus.s_wready_o, 4'b0000);
      check("t2_early_wvalid", bus.m_wvalid_o, 1'b0);
      step();
      bus.s_awvalid_i = '0;
      beats = 0;
      for (int b = 0; b < 4; b++) begin
         exp_w = mk_w(32'hA0 + 32'(b), b == 3);
         set_w(2, exp_w);
         #1;
         check("t2_m_wvalid", bus.m_wvalid_o, 1'b1);
         check("t2_m_w", bus.m_w_o, exp_w);
         check("t2_s_wready", bus.s_wready_o, 4'b0100);
         if (bus.m_wvalid_o && bus.m_wready_i) beats++;
         step();
      end
      bus.s_wvalid_i = '0;
      check("t2_beats", beats, 4);
      check("t2_resp_no_wvalid", bus.m_wvalid_o, 1'b0);
      check("t2_bvalid_before", bus.s_bvalid_o, 4'b0000);
      bus.s_bready_i = 4'b0100;
      bus.m_bvalid_i = 1'b1;
      bus.m_b_i      = {6'd5, 2'b00};
      #1;
      check("t2_s_bvalid", bus.s_bvalid_o, 4'b0100);
      check("t2_s_b", bus.s_b_o, {6'd5, 2'b00});
      check("t2_m_bready", bus.m_bready_o, 1'b1);
      step();
      bus.m_bvalid_i = 1'b0;
      bus.s_bready_i = '0;
      #1;
      check("t2_idle_busy", busy, 1'b0);
      check("t2_idle_grant", grant, 4'b0000);
      check("t2_idle_bvalid", bus.s_bvalid_o, 4'b0000);

      // 3: all slots request continuously with single-beat bursts
      do_reset();
      bus.m_awready_i = 1'b1;
      bus.m_wready_i  = 1'b1;
      bus.m_bvalid_i  = 1'b1;
      bus.s_awvalid_i = 4'b1111;
      bus.s_wvalid_i  = 4'b1111;
      bus.s_bready_i  = 4'b1111;
      for (int s = 0; s < slot_n; s++) begin
         set_aw(s, mk_aw(6'(s), 64'(s * 64), 8'd0));
         set_w(s, mk_w(32'(s), 1'b1));
      end
      for (int t = 0; t < 5; t++) begin
         exp_g = 4'b0001 << (t % 4);
         step();
         check("t3_grant", grant, exp_g);
         check("t3_s_awready", bus.s_awready_o, exp_g);
         step();
         check("t3_s_wready", bus.s_wready_o, exp_g);
         step();
         check("t3_s_bvalid", bus.s_bvalid_o, exp_g);
         step();
      end

      // 4: slot 1 presents W three cycles ahead of AW
      do_reset();
      bus.m_awready_i = 1'b1;
      bus.m_wready_i  = 1'b1;
      set_w(1, mk_w(32'h11, 1'b1));
      set_aw(1, mk_aw(6'd1, 64'h2000, 8'd0));
      bus.s_wvalid_i = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t4_pre_wready", bus.s_wready_o, 4'b0000);
         check("t4_pre_leak", bus.m_wvalid_o, 1'b0);
         step();
      end
      bus.s_awvalid_i = 4'b0010;
      step();
      check("t4_grant", grant, 4'b0010);
      check("t4_addr_wready", bus.s_wready_o, 4'b0000);
      check("t4_addr_leak", bus.m_wvalid_o, 1'b0);
      step();
      bus.s_awvalid_i = '0;
      #1;
      check("t4_data_wready", bus.s_wready_o, 4'b0010);
      check("t4_data_wvalid", bus.m_wvalid_o, 1'b1);
      step();
      bus.s_wvalid_i = '0;
      bus.s_bready_i = 4'b0010;
      bus.m_bvalid_i = 1'b1;
      step();
      check("t4_idle", busy, 1'b0);

      // 5: reset during DATA after 2 of 8 beats
      do_reset();
      bus.m_awready_i = 1'b1;
      bus.m_wready_i  = 1'b1;
      bus.s_awvalid_i = 4'b0100;
      set_aw(2, mk_aw(6'd2, 64'h3000, 8'd7));
      set_w(2, mk_w(32'h55, 1'b0));
      step();
      step();
      bus.s_awvalid_i = '0;
      bus.s_wvalid_i  = 4'b0100;
      step();
      step();
      check("t5_mid_wvalid", bus.m_wvalid_o, 1'b1);
      check("t5_mid_busy", busy, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_wvalid", bus.m_wvalid_o, 1'b0);
      check("t5_rst_wready", bus.s_wready_o, 4'b0000);
      check("t5_rst_grant", grant, 4'b0000);
      check("t5_rst_busy", busy, 1'b0);
      clear_inputs();
      step();
      rst_n = 1'b1;
      step();
      bus.s_awvalid_i = 4'b1111;
      step();
      check("t5_after_grant", grant, 4'b0001);

      // 6: W stall for timeout_p cycles
      do_reset();
      bus.m_awready_i = 1'b1;
      bus.s_awvalid_i = 4'b0001;
      set_aw(0, mk_aw(6'd9, 64'h4000, 8'd0));
      set_w(0, mk_w(32'h66, 1'b1));
      bus.s_wvalid_i = 4'b0001;
      step();
      step();
      bus.s_awvalid_i = '0;
      for (int c = 0; c < to_p - 1; c++) step();
      check("t6_to_before", timeout, 1'b0);
      step();
      check("t6_to_at_limit", timeout, to_en);
      check("t6_fsm_busy", busy, 1'b1);
      check("t6_fsm_wvalid", bus.m_wvalid_o, 1'b1);
      bus.m_wready_i = 1'b1;
      step();
      bus.s_wvalid_i = '0;
      bus.s_bready_i = 4'b0001;
      bus.m_bvalid_i = 1'b1;
      step();
      check("t6_idle", busy, 1'b0);
      check("t6_sticky", timeout, to_en);
      do_reset();
      check("t6_reset_clears", timeout, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
